// File: rtl/fli_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fli_pkg
// Description : Shared types, format constants and the rs1 decode function
//               for the Zfa float-immediate generator.
// Revision    : 1.0 - initial release
// ============================================================================
package fli_pkg;

    typedef enum logic [1:0] {
        FLI_NORM,
        FLI_MINNORM,
        FLI_INF,
        FLI_NAN
    } fli_class_t;

    typedef struct packed {
        logic              sign;
        fli_class_t        cls;
        logic signed [5:0] exp;
        logic [1:0]        man;
    } fli_dec_t;

    localparam int c_ne_h = 5;
    localparam int c_nf_h = 10;
    localparam int c_ne_s = 8;
    localparam int c_nf_s = 23;
    localparam int c_ne_d = 11;
    localparam int c_nf_d = 52;
    localparam int c_ne_q = 15;
    localparam int c_nf_q = 112;

    localparam logic [1:0] c_fmt_s = 2'b00;
    localparam logic [1:0] c_fmt_d = 2'b01;
    localparam logic [1:0] c_fmt_h = 2'b10;
    localparam logic [1:0] c_fmt_q = 2'b11;

    // Every constant is +/- 2^E * 1.m with a 2-bit mantissa, or a special class.
    function automatic fli_dec_t fli_decode(input logic [4:0] rs1);
        fli_dec_t d;
        d = '0;
        d.cls = FLI_NORM;
        case (rs1)
            5'd0:  d.sign = 1'b1;
            5'd1:  d.cls  = FLI_MINNORM;
            5'd2:  d.exp  = -6'sd16;
            5'd3:  d.exp  = -6'sd15;
            5'd4:  d.exp  = -6'sd8;
            5'd5:  d.exp  = -6'sd7;
            5'd6:  d.exp  = -6'sd4;
            5'd7:  d.exp  = -6'sd3;
            5'd8, 5'd9, 5'd10, 5'd11: begin
                d.exp = -6'sd2;
                d.man = rs1[1:0];
            end
            5'd12, 5'd13, 5'd14, 5'd15: begin
                d.exp = -6'sd1;
                d.man = rs1[1:0];
            end
            5'd16, 5'd17, 5'd18, 5'd19: begin
                d.exp = 6'sd0;
                d.man = rs1[1:0];
            end
            5'd20, 5'd21, 5'd22: begin
                d.exp = 6'sd1;
                d.man = rs1[1:0];
            end
            5'd23: d.exp  = 6'sd2;
            5'd24: d.exp  = 6'sd3;
            5'd25: d.exp  = 6'sd4;
            5'd26: d.exp  = 6'sd7;
            5'd27: d.exp  = 6'sd8;
            5'd28: d.exp  = 6'sd15;
            5'd29: d.exp  = 6'sd16;
            5'd30: d.cls  = FLI_INF;
            default: d.cls = FLI_NAN;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fli_pack.sv
`default_nettype none
// ============================================================================
// Module      : fli_pack
// Description : Packs a decoded FLI constant into H/S/D/Q and NaN-boxes it.
// Revision    : 1.0 - initial release
// ============================================================================
module fli_pack import fli_pkg::*; #(
    parameter int FLEN = 64,
    parameter bit H_EN = 1'b1,
    parameter bit D_EN = 1'b1,
    parameter bit Q_EN = 1'b0
) (
    input  fli_dec_t          i_dec,
    input  logic [1:0]        i_fmt,
    output logic [FLEN-1:0]   o_imm,
    output logic              o_illegal
);

    logic [FLEN-1:0] w_raw;

    function automatic logic [FLEN-1:0] pack_fmt(input fli_dec_t d, input int ne, input int nf);
        int              bias;
        int              b;
        logic [FLEN-1:0] one;
        logic [FLEN-1:0] manv;
        logic [FLEN-1:0] expf;
        logic [FLEN-1:0] frac;
        logic [FLEN-1:0] sgn;
        logic [FLEN-1:0] box;
        one  = {{(FLEN-1){1'b0}}, 1'b1};
        manv = {{(FLEN-2){1'b0}}, d.man};
        bias = (1 << (ne - 1)) - 1;
        b    = int'(d.exp) + bias;
        expf = '0;
        frac = '0;
        sgn  = d.sign ? (one << (ne + nf)) : '0;
        case (d.cls)
            FLI_NORM: begin
                if (b >= (1 << ne) - 1) begin
                    expf = (one << ne) - one;
                end else if (b <= 0) begin
                    // Hidden bit lands at position nf, then denormalises; all constants are exact.
                    frac = (((one << 2) | manv) << (nf - 2)) >> (1 - b);
                end else begin
                    expf = FLEN'(b);
                    frac = manv << (nf - 2);
                end
            end
            FLI_MINNORM: expf = one;
            FLI_INF:     expf = (one << ne) - one;
            default: begin
                expf = (one << ne) - one;
                frac = one << (nf - 1);
                sgn  = '0;
            end
        endcase
        box = ~((one << (ne + nf + 1)) - one);
        return box | sgn | (expf << nf) | frac;
    endfunction

    always_comb begin
        o_illegal = 1'b0;
        w_raw     = '0;
        case (i_fmt)
            c_fmt_s: begin
                o_illegal = (FLEN < 32);
                w_raw     = pack_fmt(i_dec, c_ne_s, c_nf_s);
            end
            c_fmt_d: begin
                o_illegal = !D_EN || (FLEN < 64);
                w_raw     = pack_fmt(i_dec, c_ne_d, c_nf_d);
            end
            c_fmt_h: begin
                o_illegal = !H_EN;
                w_raw     = pack_fmt(i_dec, c_ne_h, c_nf_h);
            end
            default: begin
                o_illegal = !Q_EN || (FLEN < 128);
                w_raw     = pack_fmt(i_dec, c_ne_q, c_nf_q);
            end
        endcase
        o_imm = o_illegal ? '0 : w_raw;
    end

endmodule
`default_nettype wire

// File: rtl/fli_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fli_pipe
// Description : Two-stage elastic FLI constant generator (decode, pack).
// Revision    : 1.0 - initial release
// ============================================================================
module fli_pipe import fli_pkg::*; #(
    parameter int FLEN = 64,
    parameter bit H_EN = 1'b1,
    parameter bit D_EN = 1'b1,
    parameter bit Q_EN = 1'b0,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      rs1,
    input  logic [1:0]      fmt,
    input  logic [TAGW-1:0] in_tag,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FLEN-1:0] imm,
    output logic [TAGW-1:0] out_tag,
    output logic            illegal
);

    logic            r_s1_valid;
    fli_dec_t        r_s1_dec;
    logic [1:0]      r_s1_fmt;
    logic [TAGW-1:0] r_s1_tag;
    logic            r_s2_valid;
    logic [FLEN-1:0] r_imm;
    logic [TAGW-1:0] r_tag;
    logic            r_illegal;

    logic            w_s1_load;
    logic            w_s2_load;
    fli_dec_t        w_dec;
    logic [FLEN-1:0] w_imm;
    logic            w_illegal;

    assign w_s2_load = ~r_s2_valid | out_ready;
    assign w_s1_load = ~r_s1_valid | w_s2_load;
    assign w_dec     = fli_decode(rs1);

    fli_pack #(
        .FLEN (FLEN),
        .H_EN (H_EN),
        .D_EN (D_EN),
        .Q_EN (Q_EN)
    ) u_pack (
        .i_dec     (r_s1_dec),
        .i_fmt     (r_s1_fmt),
        .o_imm     (w_imm),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_dec   <= '0;
            r_s1_fmt   <= '0;
            r_s1_tag   <= '0;
        end else begin
            // A request presented alongside flush is dropped here, even though in_ready was high.
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_load) begin
                r_s1_valid <= in_valid;
            end
            if (w_s1_load && in_valid) begin
                r_s1_dec <= w_dec;
                r_s1_fmt <= fmt;
                r_s1_tag <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_imm      <= '0;
            r_tag      <= '0;
            r_illegal  <= 1'b0;
        end else begin
            if (flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_load && r_s1_valid) begin
                r_imm     <= w_imm;
                r_tag     <= r_s1_tag;
                r_illegal <= w_illegal;
            end
        end
    end

    assign in_ready  = w_s1_load;
    assign out_valid = r_s2_valid;
    assign imm       = r_imm;
    assign out_tag   = r_tag;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_fli_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fli_pipe
// Description : Directed self-checking bench for fli_pipe (FLEN=64, Q off).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fli_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1;
    logic [1:0]  fmt;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] imm;
    logic [4:0]  out_tag;
    logic        illegal;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [15:0] H_TAB [32] = '{
        16'hBC00, 16'h0400, 16'h0100, 16'h0200, 16'h1C00, 16'h2000, 16'h2C00, 16'h3000,
        16'h3400, 16'h3500, 16'h3600, 16'h3700, 16'h3800, 16'h3900, 16'h3A00, 16'h3B00,
        16'h3C00, 16'h3D00, 16'h3E00, 16'h3F00, 16'h4000, 16'h4100, 16'h4200, 16'h4400,
        16'h4800, 16'h4C00, 16'h5800, 16'h5C00, 16'h7800, 16'h7C00, 16'h7C00, 16'h7E00};

    localparam logic [31:0] S_TAB [32] = '{
        32'hBF800000, 32'h00800000, 32'h37800000, 32'h38000000,
        32'h3B800000, 32'h3C000000, 32'h3D800000, 32'h3E000000,
        32'h3E800000, 32'h3EA00000, 32'h3EC00000, 32'h3EE00000,
        32'h3F000000, 32'h3F200000, 32'h3F400000, 32'h3F600000,
        32'h3F800000, 32'h3FA00000, 32'h3FC00000, 32'h3FE00000,
        32'h40000000, 32'h40200000, 32'h40400000, 32'h40800000,
        32'h41000000, 32'h41800000, 32'h43000000, 32'h43800000,
        32'h47000000, 32'h47800000, 32'h7F800000, 32'h7FC00000};

    // Upper 16 bits of each double; the low 48 bits are zero for every constant.
    localparam logic [15:0] D_TAB [32] = '{
        16'hBFF0, 16'h0010, 16'h3EF0, 16'h3F00, 16'h3F70, 16'h3F80, 16'h3FB0, 16'h3FC0,
        16'h3FD0, 16'h3FD4, 16'h3FD8, 16'h3FDC, 16'h3FE0, 16'h3FE4, 16'h3FE8, 16'h3FEC,
        16'h3FF0, 16'h3FF4, 16'h3FF8, 16'h3FFC, 16'h4000, 16'h4004, 16'h4008, 16'h4010,
        16'h4020, 16'h4030, 16'h4060, 16'h4070, 16'h40E0, 16'h40F0, 16'h7FF0, 16'h7FF8};

    fli_pipe #(
        .FLEN (64),
        .H_EN (1'b1),
        .D_EN (1'b1),
        .Q_EN (1'b0),
        .TAGW (5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .fmt       (fmt),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm       (imm),
        .out_tag   (out_tag),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", nm, obs, exp);
        end
    endtask

    function automatic logic [63:0] golden(input logic [1:0] f, input int i);
        case (f)
            2'b10:   return {48'hFFFF_FFFF_FFFF, H_TAB[i]};
            2'b00:   return {32'hFFFF_FFFF, S_TAB[i]};
            default: return {D_TAB[i], 48'h0};
        endcase
    endfunction

    // One isolated request: checks acceptance, the empty first cycle and the result.
    task automatic single(input string nm, input logic [1:0] f, input logic [4:0] r,
                          input logic [4:0] t, input logic [63:0] e, input logic ei);
        in_valid = 1'b1;
        fmt      = f;
        rs1      = r;
        in_tag   = t;
        #1;
        chk({nm, "_rdy"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({nm, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_imm"}, imm, e);
        chk({nm, "_tag"}, 64'(out_tag), 64'(t));
        chk({nm, "_ill"}, 64'(illegal), 64'(ei));
        @(negedge clk);
    endtask

    // Back-to-back stream of all 32 indices; each result appears two cycles later.
    task automatic sweep(input string nm, input logic [1:0] f);
        for (int i = 0; i < 34; i++) begin
            if (i < 32) begin
                in_valid = 1'b1;
                fmt      = f;
                rs1      = 5'(i);
                in_tag   = 5'(i);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i >= 2) begin
                chk({nm, "_valid"}, 64'(out_valid), 64'd1);
                chk({nm, "_imm"}, imm, golden(f, i - 2));
                chk({nm, "_tag"}, 64'(out_tag), 64'(i - 2));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        rs1       = '0;
        fmt       = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_imm", imm, 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        single("s_one", 2'b00, 5'd16, 5'd3, 64'hFFFF_FFFF_3F80_0000, 1'b0);
        single("h_min", 2'b10, 5'd2, 5'd4, 64'hFFFF_FFFF_FFFF_0100, 1'b0);
        single("h_ovf", 2'b10, 5'd29, 5'd5, 64'hFFFF_FFFF_FFFF_7C00, 1'b0);
        single("h_minnorm", 2'b10, 5'd1, 5'd6, 64'hFFFF_FFFF_FFFF_0400, 1'b0);
        single("d_four", 2'b01, 5'd23, 5'd7, 64'h4010_0000_0000_0000, 1'b0);
        single("d_nan", 2'b01, 5'd31, 5'd8, 64'h7FF8_0000_0000_0000, 1'b0);

        sweep("sweep_h", 2'b10);
        sweep("sweep_s", 2'b00);
        sweep("sweep_d", 2'b01);

        // Backpressure: two requests fit, the third waits for out_ready.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        fmt       = 2'b00;
        rs1       = 5'd16;
        in_tag    = 5'd1;
        #1;
        chk("bp_rdy_a", 64'(in_ready), 64'd1);
        @(negedge clk);
        rs1    = 5'd20;
        in_tag = 5'd2;
        #1;
        chk("bp_rdy_b", 64'(in_ready), 64'd1);
        @(negedge clk);
        rs1    = 5'd24;
        in_tag = 5'd3;
        #1;
        chk("bp_rdy_c", 64'(in_ready), 64'd0);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_imm", imm, 64'hFFFF_FFFF_3F80_0000);
        @(negedge clk);
        #1;
        chk("bp_still_stalled", 64'(in_ready), 64'd0);
        chk("bp_stable_imm", imm, 64'hFFFF_FFFF_3F80_0000);
        chk("bp_stable_tag", 64'(out_tag), 64'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp_b_valid", 64'(out_valid), 64'd1);
        chk("bp_b_imm", imm, 64'hFFFF_FFFF_4000_0000);
        chk("bp_b_tag", 64'(out_tag), 64'd2);
        @(negedge clk);
        #1;
        chk("bp_c_valid", 64'(out_valid), 64'd1);
        chk("bp_c_imm", imm, 64'hFFFF_FFFF_4100_0000);
        chk("bp_c_tag", 64'(out_tag), 64'd3);
        @(negedge clk);
        #1;
        chk("bp_drained", 64'(out_valid), 64'd0);
        @(negedge clk);

        // Flush with both stages occupied plus a same-cycle request.
        in_valid = 1'b1;
        fmt      = 2'b00;
        rs1      = 5'd16;
        in_tag   = 5'd9;
        @(negedge clk);
        rs1    = 5'd17;
        in_tag = 5'd10;
        @(negedge clk);
        rs1    = 5'd18;
        in_tag = 5'd11;
        flush  = 1'b1;
        #1;
        chk("fl_two_inflight", 64'(out_valid), 64'd1);
        chk("fl_rdy_normal", 64'(in_ready), 64'd1);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fl_next_cycle", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        chk("fl_no_stale_1", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        chk("fl_no_stale_2", 64'(out_valid), 64'd0);
        @(negedge clk);

        single("q_illegal", 2'b11, 5'd16, 5'd12, 64'd0, 1'b1);

        // Asynchronous reset while the pipe is stalled full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        fmt       = 2'b00;
        rs1       = 5'd16;
        in_tag    = 5'd13;
        @(negedge clk);
        rs1    = 5'd17;
        in_tag = 5'd14;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("ar_stalled_valid", 64'(out_valid), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_imm", imm, 64'd0);
        chk("ar_tag", 64'(out_tag), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        single("ar_after", 2'b00, 5'd20, 5'd15, 64'hFFFF_FFFF_4000_0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
